// File: rtl/traffic_light_ctrl.sv
// Intersection sequencer: main/side roads plus pedestrian crossing, paced by an upstream tick.
// Phases are timed in ticks; side and pedestrian requests are latched until served.
module traffic_light_ctrl #(
    parameter int MAIN_GREEN = 10,
    parameter int SIDE_GREEN = 5,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 1,
    parameter int WALK_TIME  = 4
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor_side,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state,
    output logic       phase_done
);

    localparam logic [2:0] S_MAIN_G  = 3'd0;
    localparam logic [2:0] S_MAIN_Y  = 3'd1;
    localparam logic [2:0] S_ALLRED1 = 3'd2;
    localparam logic [2:0] S_SIDE_G  = 3'd3;
    localparam logic [2:0] S_SIDE_Y  = 3'd4;
    localparam logic [2:0] S_ALLRED2 = 3'd5;
    localparam logic [2:0] S_WALK    = 3'd6;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Terminal count of each phase: the phase ends on the tick seen at DUR-1.
    localparam logic [5:0] MG_LAST = 6'(MAIN_GREEN - 1);
    localparam logic [5:0] SG_LAST = 6'(SIDE_GREEN - 1);
    localparam logic [5:0] Y_LAST  = 6'(YELLOW - 1);
    localparam logic [5:0] AR_LAST = 6'(ALL_RED - 1);
    localparam logic [5:0] WK_LAST = 6'(WALK_TIME - 1);

    logic [2:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       side_pend_q, side_pend_d;
    logic       ped_pend_q, ped_pend_d;
    logic       phase_done_q, phase_done_d;
    logic       transition;

    // State register and datapath registers
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q      <= S_MAIN_G;
            cnt_q        <= 6'd0;
            side_pend_q  <= 1'b0;
            ped_pend_q   <= 1'b0;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            side_pend_q  <= side_pend_d;
            ped_pend_q   <= ped_pend_d;
            phase_done_q <= phase_done_d;
        end
    end

    // Next-state logic; the unused code 7 falls back to MAIN_G without waiting for a tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MAIN_G: begin
                if (tick && (cnt_q == MG_LAST) && (side_pend_q || ped_pend_q))
                    state_d = S_MAIN_Y;
            end
            S_MAIN_Y: begin
                if (tick && (cnt_q == Y_LAST))
                    state_d = S_ALLRED1;
            end
            S_ALLRED1: begin
                if (tick && (cnt_q == AR_LAST))
                    state_d = ped_pend_q ? S_WALK : S_SIDE_G;
            end
            S_SIDE_G: begin
                if (tick && (cnt_q == SG_LAST))
                    state_d = S_SIDE_Y;
            end
            S_SIDE_Y: begin
                if (tick && (cnt_q == Y_LAST))
                    state_d = S_ALLRED2;
            end
            S_WALK: begin
                if (tick && (cnt_q == WK_LAST))
                    state_d = S_ALLRED2;
            end
            S_ALLRED2: begin
                if (tick && (cnt_q == AR_LAST))
                    state_d = S_MAIN_G;
            end
            default: state_d = S_MAIN_G;
        endcase
    end

    assign transition = (state_d != state_q);

    // Phase counter; MAIN_G parks at its minimum so a late request leaves on the next tick.
    always_comb begin
        cnt_d = cnt_q;
        if (transition) begin
            cnt_d = 6'd0;
        end else if (tick) begin
            if ((state_q == S_MAIN_G) && (cnt_q == MG_LAST))
                cnt_d = cnt_q;
            else
                cnt_d = cnt_q + 6'd1;
        end
    end

    // Request latches: clearing on entry to the serving phase wins over a same-cycle set.
    always_comb begin
        side_pend_d = side_pend_q | sensor_side;
        ped_pend_d  = ped_pend_q | ped_req;
        if (transition && (state_d == S_SIDE_G))
            side_pend_d = 1'b0;
        if (transition && (state_d == S_WALK))
            ped_pend_d = 1'b0;
        phase_done_d = transition;
    end

    // Moore output decode; any unexpected code shows all red.
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
        case (state_q)
            S_MAIN_G: begin
                main_light = LAMP_GREEN;
                side_light = LAMP_RED;
            end
            S_MAIN_Y: begin
                main_light = LAMP_YELLOW;
                side_light = LAMP_RED;
            end
            S_SIDE_G: begin
                main_light = LAMP_RED;
                side_light = LAMP_GREEN;
            end
            S_SIDE_Y: begin
                main_light = LAMP_RED;
                side_light = LAMP_YELLOW;
            end
            S_WALK: begin
                walk = 1'b1;
            end
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign state      = state_q;
    assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: hand-derived state sequences per tick, lamp safety on every cycle.
// A second instance with unit durations runs with tick tied high.
module tb_traffic_light_ctrl;

    logic       clk_out = 1'b0;
    logic       reset;
    logic       tick;
    logic       sensor_side;
    logic       ped_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] state;
    logic       phase_done;

    logic       fast_reset;
    logic       fast_tick;
    logic       fast_sensor;
    logic       fast_ped;
    logic [2:0] fast_main;
    logic [2:0] fast_side;
    logic       fast_walk;
    logic [2:0] fast_state;
    logic       fast_phase_done;

    int n_checks = 0;
    int n_fail   = 0;
    int pd_cnt   = 0;

    always #5 clk_out = ~clk_out;

    traffic_light_ctrl u_dut (
        .clk_out     (clk_out),
        .reset       (reset),
        .tick        (tick),
        .sensor_side (sensor_side),
        .ped_req     (ped_req),
        .main_light  (main_light),
        .side_light  (side_light),
        .walk        (walk),
        .state       (state),
        .phase_done  (phase_done)
    );

    traffic_light_ctrl #(
        .MAIN_GREEN (1),
        .SIDE_GREEN (1),
        .YELLOW     (1),
        .ALL_RED    (1)
    ) u_fast (
        .clk_out     (clk_out),
        .reset       (fast_reset),
        .tick        (fast_tick),
        .sensor_side (fast_sensor),
        .ped_req     (fast_ped),
        .main_light  (fast_main),
        .side_light  (fast_side),
        .walk        (fast_walk),
        .state       (fast_state),
        .phase_done  (fast_phase_done)
    );

    // One clock with the given tick value; samples 1 time unit after the edge.
    task automatic step(input logic t);
        tick = t;
        @(posedge clk_out);
        #1;
        tick = 1'b0;
        if (phase_done === 1'b1) pd_cnt++;
        n_checks++;
        if (((main_light !== 3'b100) && (side_light !== 3'b100)) ||
            ((walk !== 1'b0) && ((main_light !== 3'b100) || (side_light !== 3'b100)))) begin
            n_fail++;
            $display("FAIL safety: main=%b side=%b walk=%b", main_light, side_light, walk);
        end
    endtask

    task automatic tick_once();
        step(1'b0);
        step(1'b1);
    endtask

    task automatic do_reset();
        tick        = 1'b0;
        sensor_side = 1'b0;
        ped_req     = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk_out);
        #1;
        reset  = 1'b0;
        pd_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if (state !== 3'd0 || main_light !== 3'b001 || side_light !== 3'b100 ||
            walk !== 1'b0 || phase_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d main=%b side=%b walk=%b pd=%b want 0/001/100/0/0",
                     state, main_light, side_light, walk, phase_done);
        end
        do_reset();
    endtask

    task automatic test_no_requests();
        do_reset();
        for (int t = 1; t <= 100; t++) begin
            tick_once();
            n_checks++;
            if (state !== 3'd0 || main_light !== 3'b001 || side_light !== 3'b100) begin
                n_fail++;
                $display("FAIL idle_main_g tick %0d: state=%0d main=%b side=%b want 0/001/100",
                         t, state, main_light, side_light);
            end
        end
        step(1'b0);
        n_checks++;
        if (pd_cnt !== 0) begin
            n_fail++;
            $display("FAIL idle_phase_done: pulses=%0d want 0", pd_cnt);
        end
    endtask

    task automatic test_side_request();
        logic [2:0] exp_st;
        do_reset();
        for (int t = 1; t <= 23; t++) begin
            if (t == 3) begin
                sensor_side = 1'b1;
                step(1'b0);
                sensor_side = 1'b0;
            end
            tick_once();
            exp_st = (t < 10) ? 3'd0 : (t < 13) ? 3'd1 : (t < 14) ? 3'd2 :
                     (t < 19) ? 3'd3 : (t < 22) ? 3'd4 : (t < 23) ? 3'd5 : 3'd0;
            n_checks++;
            if (state !== exp_st) begin
                n_fail++;
                $display("FAIL side_seq tick %0d: state=%0d want %0d", t, state, exp_st);
            end
            if (t == 14) begin
                n_checks++;
                if (side_light !== 3'b001 || main_light !== 3'b100) begin
                    n_fail++;
                    $display("FAIL side_green_lamps: main=%b side=%b want 100/001", main_light, side_light);
                end
            end
        end
        step(1'b0);
        n_checks++;
        if (pd_cnt !== 6) begin
            n_fail++;
            $display("FAIL side_phase_done: pulses=%0d want 6", pd_cnt);
        end
    endtask

    task automatic test_ped_request();
        logic [2:0] exp_st;
        logic       exp_walk;
        do_reset();
        ped_req = 1'b1;
        step(1'b0);
        ped_req = 1'b0;
        for (int t = 1; t <= 19; t++) begin
            tick_once();
            exp_st = (t < 10) ? 3'd0 : (t < 13) ? 3'd1 : (t < 14) ? 3'd2 :
                     (t < 18) ? 3'd6 : (t < 19) ? 3'd5 : 3'd0;
            exp_walk = (t >= 14) && (t <= 17);
            n_checks++;
            if (state !== exp_st || walk !== exp_walk || side_light !== 3'b100) begin
                n_fail++;
                $display("FAIL ped_seq tick %0d: state=%0d walk=%b side=%b want %0d/%b/100",
                         t, state, walk, side_light, exp_st, exp_walk);
            end
            if (t == 10) begin
                // Tick held low: the FSM must not move.
                repeat (20) step(1'b0);
                n_checks++;
                if (state !== 3'd1) begin
                    n_fail++;
                    $display("FAIL tick_freeze: state=%0d want 1", state);
                end
            end
        end
        step(1'b0);
        n_checks++;
        if (pd_cnt !== 5) begin
            n_fail++;
            $display("FAIL ped_phase_done: pulses=%0d want 5", pd_cnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_st;
        do_reset();
        sensor_side = 1'b1;
        ped_req     = 1'b1;
        step(1'b0);
        sensor_side = 1'b0;
        for (int t = 1; t <= 42; t++) begin
            if (t == 15) ped_req = 1'b0;
            tick_once();
            exp_st = (t < 10) ? 3'd0 : (t < 13) ? 3'd1 : (t < 14) ? 3'd2 :
                     (t < 18) ? 3'd6 : (t < 19) ? 3'd5 : (t < 29) ? 3'd0 :
                     (t < 32) ? 3'd1 : (t < 33) ? 3'd2 : (t < 38) ? 3'd3 :
                     (t < 41) ? 3'd4 : (t < 42) ? 3'd5 : 3'd0;
            n_checks++;
            if (state !== exp_st) begin
                n_fail++;
                $display("FAIL both_seq tick %0d: state=%0d want %0d", t, state, exp_st);
            end
        end
        step(1'b0);
        n_checks++;
        if (pd_cnt !== 11) begin
            n_fail++;
            $display("FAIL both_phase_done: pulses=%0d want 11", pd_cnt);
        end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        sensor_side = 1'b1;
        step(1'b0);
        sensor_side = 1'b0;
        repeat (15) tick_once();
        n_checks++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL reach_side_g: state=%0d want 3", state);
        end
        sensor_side = 1'b1;
        step(1'b0);
        sensor_side = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 3'd0 || main_light !== 3'b001 || side_light !== 3'b100 || walk !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d main=%b side=%b walk=%b want 0/001/100/0",
                     state, main_light, side_light, walk);
        end
        @(posedge clk_out);
        #1;
        reset  = 1'b0;
        pd_cnt = 0;
        for (int t = 1; t <= 100; t++) begin
            tick_once();
            n_checks++;
            if (state !== 3'd0) begin
                n_fail++;
                $display("FAIL post_reset_hold tick %0d: state=%0d want 0", t, state);
            end
        end
        step(1'b0);
        n_checks++;
        if (pd_cnt !== 0) begin
            n_fail++;
            $display("FAIL post_reset_phase_done: pulses=%0d want 0", pd_cnt);
        end
    endtask

    task automatic test_continuous_tick();
        logic [2:0] exp_st;
        fast_sensor = 1'b1;
        @(posedge clk_out);
        #1;
        fast_reset = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            @(posedge clk_out);
            #1;
            exp_st = (n == 1) ? 3'd0 : 3'((n - 1) % 6);
            n_checks++;
            if (fast_state !== exp_st) begin
                n_fail++;
                $display("FAIL fast_seq clk %0d: state=%0d want %0d", n, fast_state, exp_st);
            end
            if (n >= 3) begin
                n_checks++;
                if (fast_phase_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fast_phase_done clk %0d: pd=%b want 1", n, fast_phase_done);
                end
            end
            if (exp_st == 3'd3) begin
                n_checks++;
                if (fast_side !== 3'b001 || fast_main !== 3'b100) begin
                    n_fail++;
                    $display("FAIL fast_side_green clk %0d: main=%b side=%b want 100/001",
                             n, fast_main, fast_side);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        tick        = 1'b0;
        sensor_side = 1'b0;
        ped_req     = 1'b0;
        fast_reset  = 1'b1;
        fast_tick   = 1'b1;
        fast_sensor = 1'b0;
        fast_ped    = 1'b0;

        test_reset();
        test_no_requests();
        test_side_request();
        test_ped_request();
        test_simultaneous();
        test_reset_mid_phase();
        test_continuous_tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
